// File: rtl/fmv_check_pkg.sv
// fmv_check_pkg: shared state encoding, default parameters and sizing helper for the output checker
package fmv_check_pkg;

    localparam int DEF_WIDTH       = 1;
    localparam int DEF_SKIP_CYCLES = 1;
    localparam int DEF_RUN_CYCLES  = 400;
    localparam int DEF_CNT_W       = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SKIP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // The sample counter only ever holds 0..max(skip,run)-1 because it is cleared on each phase change
    function automatic int idx_width(input int skip_n, input int run_n);
        int m;
        m = (skip_n > run_n) ? skip_n : run_n;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/fmv_sat_counter.sv
// fmv_sat_counter: up counter with synchronous clear that holds at all-ones instead of wrapping
module fmv_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // clear has priority over counting; a full counter stays full
    always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    // counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fmv_output_checker.sv
// fmv_output_checker: compares fabric outputs against a reference over a bounded run, masking unknown bits
module fmv_output_checker
    import fmv_check_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SKIP_CYCLES = DEF_SKIP_CYCLES,
    parameter int RUN_CYCLES  = DEF_RUN_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] dut_out,
    input  logic [WIDTH-1:0] ref_out,
    input  logic [WIDTH-1:0] ref_known,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_bits
);

    localparam int IDX_W = idx_width(SKIP_CYCLES, RUN_CYCLES);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             start_ok;
    logic             in_skip;
    logic             in_run;
    logic             skip_last;
    logic             run_last;
    logic             fail;
    logic             first_fail;
    logic             cnt_clr;
    logic [WIDTH-1:0] fail_bits;
    logic [IDX_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_idx_q;
    logic [CNT_W-1:0] first_idx_d;
    logic [WIDTH-1:0] first_bits_q;
    logic [WIDTH-1:0] first_bits_d;
    logic             mismatch_q;

    assign start_ok   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign in_skip    = sample_valid && state_q == ST_SKIP;
    assign in_run     = sample_valid && state_q == ST_RUN;
    assign skip_last  = in_skip && sample_cnt == IDX_W'(SKIP_CYCLES - 1);
    assign run_last   = in_run && sample_cnt == IDX_W'(RUN_CYCLES - 1);
    assign fail_bits  = (dut_out ^ ref_out) & ref_known;
    assign fail       = in_run && |fail_bits;
    assign first_fail = fail && err_cnt == '0;
    assign cnt_clr    = start_ok | skip_last | run_last;

    // run sequencing: start is honoured only when not busy, and each phase ends on its last valid sample
    always_comb state_d = start_ok  ? ((SKIP_CYCLES > 0) ? ST_SKIP : ST_RUN) :
                          skip_last ? ST_RUN :
                          run_last  ? ST_DONE : state_q;

    // first-failure capture; err_count never returns to zero within a run, so zero marks "no failure yet"
    always_comb begin
        first_idx_d  = start_ok ? '0 : first_fail ? CNT_W'(sample_cnt) : first_idx_q;
        first_bits_d = start_ok ? '0 : first_fail ? fail_bits : first_bits_q;
    end

    // state, first-failure record and the registered mismatch pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            first_idx_q  <= '0;
            first_bits_q <= '0;
            mismatch_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_idx_q  <= first_idx_d;
            first_bits_q <= first_bits_d;
            mismatch_q   <= fail;
        end
    end

    fmv_sat_counter #(.W(IDX_W)) u_sample_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (in_skip | in_run),
        .cnt_o (sample_cnt)
    );

    fmv_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start_ok),
        .en_i  (fail),
        .cnt_o (err_cnt)
    );

    assign busy           = state_q == ST_SKIP || state_q == ST_RUN;
    assign done           = state_q == ST_DONE;
    assign pass           = done && err_cnt == '0;
    assign mismatch       = mismatch_q;
    assign err_count      = err_cnt;
    assign first_err_idx  = first_idx_q;
    assign first_err_bits = first_bits_q;

endmodule
